// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU (AND/OR/ADD/SUB/NOR), one bit slice per clock, LSB first.
// Define ALU_SERIAL_OVF_EN to compile in signed-overflow detection; otherwise Overflow is tied to 0.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] acc;
  logic [3:0]       op_r;
  logic             cy;
  logic [CNT_W-1:0] cnt;

  logic             b_eff;
  logic             slice_bit;
  logic             cy_next;
  logic [WIDTH-1:0] res_next;
  logic             last_slice;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    b_eff     = (op_r == OP_SUB) ? ~b_sh[0] : b_sh[0];
    slice_bit = 1'b0;
    cy_next   = 1'b0;
    case (op_r)
      OP_AND: slice_bit = a_sh[0] & b_sh[0];
      OP_OR:  slice_bit = a_sh[0] | b_sh[0];
      OP_NOR: slice_bit = ~(a_sh[0] | b_sh[0]);
      OP_ADD, OP_SUB: begin
        slice_bit = a_sh[0] ^ b_eff ^ cy;
        cy_next   = (a_sh[0] & b_eff) | (cy & (a_sh[0] ^ b_eff));
      end
      default: begin
        slice_bit = 1'b0;
        cy_next   = 1'b0;
      end
    endcase
    res_next   = {slice_bit, acc};
    last_slice = (state == RUN) && (cnt == LAST_BIT);
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      op_r     <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_r  <= ALUOp;
            cy    <= (ALUOp == OP_SUB);
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          acc  <= res_next[WIDTH-1:1];
          cy   <= cy_next;
          cnt  <= cnt + CNT_W'(1);
          // Outputs are only committed on the final slice so they stay stable during RUN.
          if (last_slice) begin
            Result   <= res_next;
            Zero     <= (res_next == '0);
            CarryOut <= cy_next;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  // Signed overflow: carry into the MSB slice differs from carry out of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      Overflow <= 1'b0;
    end else if (last_slice) begin
      Overflow <= ((op_r == OP_ADD) || (op_r == OP_SUB)) ? (cy ^ cy_next) : 1'b0;
    end
  end
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8): arithmetic reference model plus directed vectors.
// Overflow expectations follow ALU_SERIAL_OVF_EN.
module tb_alu_serial_ctrl;

  localparam int W = 8;

`ifdef ALU_SERIAL_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ALUOp;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic         CarryOut;
  logic         Zero;
  logic         Overflow;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUOp(ALUOp),
    .busy(busy), .done(done), .Result(Result), .CarryOut(CarryOut),
    .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-word arithmetic, no bit slicing.
  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } res_t;

  function automatic res_t golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op);
    res_t     g;
    logic [W:0] s;
    g = '0;
    s = '0;
    case (op)
      4'b0000: g.r = x & y;
      4'b0001: g.r = x | y;
      4'b1100: g.r = ~(x | y);
      4'b0010: begin
        s    = {1'b0, x} + {1'b0, y};
        g.r  = s[W-1:0];
        g.co = s[W];
        g.ov = (x[W-1] == y[W-1]) && (g.r[W-1] != x[W-1]);
      end
      4'b0110: begin
        s    = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
        g.r  = s[W-1:0];
        g.co = s[W];
        g.ov = (x[W-1] != y[W-1]) && (g.r[W-1] != x[W-1]);
      end
      default: g = '0;
    endcase
    g.ov = g.ov & OVF_ON;
    return g;
  endfunction

  // m_left = cycles of busy still ahead; 1 means the done cycle.
  int           m_left = 0;
  res_t         m_pend = '0;
  logic [W-1:0] m_res  = '0;
  logic         m_co   = 1'b0;
  logic         m_z    = 1'b1;
  logic         m_ov   = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0;
      m_res  <= '0;
      m_co   <= 1'b0;
      m_z    <= 1'b1;
      m_ov   <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend <= golden(a, b, ALUOp);
        m_left <= W + 1;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_res <= m_pend.r;
        m_co  <= m_pend.co;
        m_z   <= (m_pend.r == '0);
        m_ov  <= m_pend.ov;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_left != 0);
      check("done", done, m_left == 1);
      if (m_left <= 1) begin
        check("Result", Result, m_res);
        check("CarryOut", CarryOut, m_co);
        check("Zero", Zero, m_z);
        check("Overflow", Overflow, m_ov);
      end
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [3:0] op, input logic [W-1:0] er, input logic eco,
                        input logic ez, input logic eov);
    int lat;
    @(negedge clk);
    a = x; b = y; ALUOp = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, W + 1);
    check({name, " Result"}, Result, er);
    check({name, " CarryOut"}, CarryOut, eco);
    check({name, " Zero"}, Zero, ez);
    check({name, " Overflow"}, Overflow, eov);
    @(negedge clk);
    check({name, " done pulse width"}, done, 1'b0);
  endtask

  initial begin
    int           dones;
    int           lat;
    int           t;
    int           first;
    int           second;
    logic [W-1:0] got;

    reset = 1'b1; start = 1'b1; a = 8'h55; b = 8'h11; ALUOp = 4'b0010;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset beats start busy", busy, 1'b0);
    check("reset Result", Result, 8'h00);
    check("reset Zero", Zero, 1'b1);
    check("reset CarryOut", CarryOut, 1'b0);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);

    run_op("add 7f+01",  8'h7F, 8'h01, 4'b0010, 8'h80, 1'b0, 1'b0, OVF_ON);
    run_op("sub 05-05",  8'h05, 8'h05, 4'b0110, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("add ff+01",  8'hFF, 8'h01, 4'b0010, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("and",        8'hF0, 8'h3C, 4'b0000, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("or",         8'hF0, 8'h3C, 4'b0001, 8'hFC, 1'b0, 1'b0, 1'b0);
    run_op("nor",        8'hF0, 8'h3C, 4'b1100, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op("illegal op", 8'hAA, 8'h55, 4'b0101, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op("sub 03-05",  8'h03, 8'h05, 4'b0110, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub 80-01",  8'h80, 8'h01, 4'b0110, 8'h7F, 1'b1, 1'b0, OVF_ON);

    // Start re-asserted with new operands mid-RUN must be ignored.
    @(negedge clk);
    a = 8'h12; b = 8'h34; ALUOp = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; lat = 0; got = '0;
    for (int i = 1; i <= W + 4; i++) begin
      if (done) begin
        dones++;
        got = Result;
        lat = i;
      end
      if (i == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; ALUOp = 4'b0110;
      end
      if (i == 5) start = 1'b0;
      @(negedge clk);
    end
    check("ignore: done count", dones, 1);
    check("ignore: Result", got, 8'h46);
    check("ignore: latency", lat, W + 1);

    // Reset on the third RUN cycle abandons the operation.
    a = 8'h10; b = 8'h20; ALUOp = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun reset busy", busy, 1'b0);
    check("midrun reset Result", Result, 8'h00);
    check("midrun reset done", done, 1'b0);
    reset = 1'b0;
    dones = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrun reset no done", dones, 0);
    run_op("after reset", 8'h10, 8'h20, 4'b0010, 8'h30, 1'b0, 1'b0, 1'b0);

    // Start held high: one operation per W+2 cycles.
    @(negedge clk);
    a = 8'h03; b = 8'h04; ALUOp = 4'b0010; start = 1'b1;
    t = 0; first = -1; second = -1;
    while (second < 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (done) begin
        if (first < 0) first = t;
        else second = t;
      end
    end
    start = 1'b0;
    check("back-to-back spacing", second - first, W + 2);
    check("back-to-back Result", Result, 8'h07);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
